width_convert: RTL and testbench
================================

WIDTH_CONVERT -- requirements
Module: width_convert

Interface
REQ-001 The block SHALL have parameter IN_W, default 3, input sample width in bits (>=2).
REQ-002 The block SHALL have parameter OUT_W, default 5, output sample width in bits (>=2); OUT_W may be greater than, equal to or less than IN_W.
REQ-003 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port in_valid  input  1  upstream sample present.
REQ-006 The block SHALL have port in_ready  output  1  block can accept a sample this cycle.
REQ-007 The block SHALL have port in_data  input  IN_W  input sample.
REQ-008 The block SHALL have port in_signed  input  1  1 = two's-complement sample, 0 = unsigned sample; qualified by in_valid.
REQ-009 The block SHALL have port out_valid  output  1  registered sample present.
REQ-010 The block SHALL have port out_ready  input  1  downstream accepts the sample.
REQ-011 The block SHALL have port out_data  output  OUT_W  converted sample.
REQ-012 The block SHALL have port out_sat  output  1  out_data was clamped; travels with out_data.
REQ-013 The block SHALL have port sat_count  output  16  number of clamped samples accepted downstream.

Function
REQ-014 Input transfer SHALL occur when in_valid && in_ready; output transfer when out_valid && out_ready.
REQ-015 in_ready SHALL equal !out_valid || out_ready (single register stage, full throughput).
REQ-016 Latency SHALL be one clock: a sample transferred at edge N appears on out_data with out_valid=1 after edge N.
REQ-017 With out_valid=1 and out_ready=0, out_data, out_sat and out_valid SHALL hold unchanged.
REQ-018 If an output transfer occurs with no input transfer, out_valid SHALL clear at the same edge.
REQ-019 Simultaneous input and output transfer SHALL load the new sample; out_valid stays 1.
REQ-020 Widening (OUT_W >= IN_W) SHALL sign-extend when in_signed=1 and zero-extend when in_signed=0; out_sat=0.
REQ-021 Narrowing (OUT_W < IN_W) SHALL check whether the value is representable in OUT_W bits of the same signedness.
REQ-022 Representable narrowed values SHALL pass unchanged (low OUT_W bits) with out_sat=0.
REQ-023 Unrepresentable narrowed values SHALL be handled per REQ-029/REQ-030.
REQ-024 in_signed SHALL be sampled per sample; consecutive samples may use different modes.
REQ-025 sat_count SHALL increment by 1 on each output transfer with out_sat=1, and SHALL stick at 16'hFFFF.

Reset
REQ-026 On rst=1 at a clock edge: out_valid=0, out_data=0, out_sat=0, sat_count=0; rst overrides any concurrent transfer.
REQ-027 in_ready SHALL be 1 during and after reset (out_valid=0); a sample held in the register when rst asserts SHALL be discarded.
REQ-028 After rst deasserts, the first input transfer SHALL be accepted on the next edge.

Configuration
REQ-029 With WIDTH_CONVERT_SAT_EN defined, unrepresentable narrowed values SHALL clamp to the OUT_W max/min of the sample's signedness (signed: 0111..1 / 1000..0; unsigned: 11..1), with out_sat=1.
REQ-030 Without WIDTH_CONVERT_SAT_EN, narrowing SHALL truncate to the low OUT_W bits; out_sat and sat_count SHALL be tied to 0.

Verification
REQ-031 IN_W=3, OUT_W=5, in_signed=1, in_data=3'b100 -> out_data=5'b11100 (-4) one clock later, out_sat=0.
REQ-032 IN_W=3, OUT_W=5, in_signed=0, in_data=3'b100 -> out_data=5'b00100 (4), out_sat=0.
REQ-033 IN_W=5, OUT_W=3, signed, in_data=5'b01010 (+10) -> SAT_EN: 3'b011, out_sat=1, sat_count=1 after output transfer; no SAT_EN: 3'b010, out_sat=0; 5'b11110 (-2) -> 3'b110, out_sat=0 in both builds.
REQ-034 Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and out_data holds the first sample; out_ready=1 -> next sample loads at the same edge with no bubble.
REQ-035 rst=1 while out_valid=1 and out_ready=0 -> next edge out_valid=0, sat_count=0, in_ready=1; the held sample is never transferred.
REQ-036 Drive 65537 saturating samples with out_ready=1 (SAT_EN) -> sat_count=16'hFFFF and holds.

Source files
------------

// File: rtl/width_convert.sv
// Width converter: one registered valid/ready stage that resizes each sample from IN_W to OUT_W
// bits. Widening sign- or zero-extends according to the per-sample in_signed flag.
// Narrowing truncates by default. Define WIDTH_CONVERT_SAT_EN to clamp narrowed values that
// do not fit; clamped samples set out_sat and are counted in sat_count.
module width_convert #(
    parameter int unsigned IN_W  = 3,
    parameter int unsigned OUT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_sat,
    output logic [15:0]      sat_count
);

    logic [OUT_W-1:0] conv_data;
    logic             conv_sat;
    logic             valid_q;
    logic [OUT_W-1:0] data_q;
    logic             sat_q;
    logic             in_xfer;
    logic             out_xfer;

    generate
        if (OUT_W > IN_W) begin : g_widen
            assign conv_data = {{(OUT_W - IN_W){in_signed & in_data[IN_W-1]}}, in_data};
            assign conv_sat  = 1'b0;
        end else if (OUT_W == IN_W) begin : g_same
            assign conv_data = in_data;
            assign conv_sat  = 1'b0;
        end else begin : g_narrow
`ifdef WIDTH_CONVERT_SAT_EN
            // The bits from the new MSB upward must all match for a signed value to fit.
            // For an unsigned value, every bit above the new MSB must be zero.
            logic [IN_W-OUT_W:0] top_bits;
            logic                fits;
            assign top_bits = in_data[IN_W-1:OUT_W-1];

            // Keep the value when it fits; otherwise clamp to the range limit of its signedness.
            always_comb begin
                conv_data = in_data[OUT_W-1:0];
                conv_sat  = 1'b0;
                if (in_signed) begin
                    fits = (top_bits == '0) || (top_bits == '1);
                end else begin
                    fits = (top_bits[IN_W-OUT_W:1] == '0);
                end
                if (!fits) begin
                    conv_sat = 1'b1;
                    if (!in_signed) begin
                        conv_data = '1;
                    end else if (in_data[IN_W-1]) begin
                        conv_data = {1'b1, {(OUT_W - 1){1'b0}}};
                    end else begin
                        conv_data = {1'b0, {(OUT_W - 1){1'b1}}};
                    end
                end
            end
`else
            assign conv_data = in_data[OUT_W-1:0];
            assign conv_sat  = 1'b0;
`endif
        end
    endgenerate

    assign in_ready  = !valid_q || out_ready;
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = valid_q && out_ready;
    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_sat   = sat_q;

    // Output register: load on input transfer, drain on output-only transfer, else hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            sat_q   <= 1'b0;
        end else if (in_xfer) begin
            valid_q <= 1'b1;
            data_q  <= conv_data;
            sat_q   <= conv_sat;
        end else if (out_xfer) begin
            valid_q <= 1'b0;
        end
    end

`ifdef WIDTH_CONVERT_SAT_EN
    logic [15:0] count_q;

    // Count clamped samples as they leave; the count sticks at its maximum.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (out_xfer && sat_q && (count_q != 16'hFFFF)) begin
            count_q <= count_q + 16'd1;
        end
    end

    assign sat_count = count_q;
`else
    assign sat_count = '0;
`endif

endmodule

// File: tb/tb_width_convert.sv
// Testbench for width_convert. It instantiates a widening instance (3->5) and a narrowing
// instance (5->3). Transfers are scoreboarded against an integer-arithmetic model.
// Both builds are covered: with and without WIDTH_CONVERT_SAT_EN.
module tb_width_convert;

    typedef struct packed {
        logic [31:0] data;
        logic        sat;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       a_in_valid, a_in_ready, a_in_signed, a_out_valid, a_out_ready, a_out_sat;
    logic [2:0] a_in_data;
    logic [4:0] a_out_data;
    logic [15:0] a_sat_count;

    logic       b_in_valid, b_in_ready, b_in_signed, b_out_valid, b_out_ready, b_out_sat;
    logic [4:0] b_in_data;
    logic [2:0] b_out_data;
    logic [15:0] b_sat_count;

    width_convert #(.IN_W(3), .OUT_W(5)) u_wide (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .in_data   (a_in_data),
        .in_signed (a_in_signed),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out_data  (a_out_data),
        .out_sat   (a_out_sat),
        .sat_count (a_sat_count)
    );

    width_convert #(.IN_W(5), .OUT_W(3)) u_narrow (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_data   (b_in_data),
        .in_signed (b_in_signed),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_data  (b_out_data),
        .out_sat   (b_out_sat),
        .sat_count (b_sat_count)
    );

    int   checks = 0;
    int   errors = 0;
    exp_t q [2][$];
    int   model_cnt [2];
    logic hold_prev [2];
    logic rst_prev [2];
    logic [31:0] prev_data [2];
    logic prev_sat [2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: interpret the input as an integer, then keep or clamp it against the OUT_W range.
    function automatic exp_t model(input int in_w, input int out_w, input logic [31:0] d,
                                   input logic sgn);
        exp_t e;
        int   v;
        v = int'(d);
        if (sgn && d[in_w-1]) v = v - (1 << in_w);
        e.sat = 1'b0;
`ifdef WIDTH_CONVERT_SAT_EN
        begin
            int lo, hi;
            lo = sgn ? -(1 << (out_w - 1)) : 0;
            hi = sgn ? (1 << (out_w - 1)) - 1 : (1 << out_w) - 1;
            if (v < lo) begin
                v = lo;
                e.sat = 1'b1;
            end else if (v > hi) begin
                v = hi;
                e.sat = 1'b1;
            end
        end
`endif
        e.data = 32'(v & ((1 << out_w) - 1));
        return e;
    endfunction

    task automatic observe(input int idx, input int in_w, input int out_w,
                           input logic iv, input logic ir, input logic [31:0] id, input logic isg,
                           input logic ov, input logic orr, input logic [31:0] od,
                           input logic osat, input logic [31:0] cnt);
        exp_t e;
        check($sformatf("in_ready[%0d]", idx), 32'(ir), 32'(!ov || orr));
        check($sformatf("out_valid[%0d]", idx), 32'(ov), 32'(q[idx].size() != 0));
        check($sformatf("sat_count[%0d]", idx), cnt, 32'(model_cnt[idx]));
        if (rst_prev[idx]) begin
            check($sformatf("rst_data[%0d]", idx), od, 32'd0);
            check($sformatf("rst_sat[%0d]", idx), 32'(osat), 32'd0);
        end else if (hold_prev[idx]) begin
            check($sformatf("hold_data[%0d]", idx), od, prev_data[idx]);
            check($sformatf("hold_sat[%0d]", idx), 32'(osat), 32'(prev_sat[idx]));
        end
        if (rst) begin
            q[idx].delete();
            model_cnt[idx] = 0;
        end else begin
            if (ov && orr && q[idx].size() != 0) begin
                e = q[idx].pop_front();
                check($sformatf("out_data[%0d]", idx), od, e.data);
                check($sformatf("out_sat[%0d]", idx), 32'(osat), 32'(e.sat));
                if (e.sat && model_cnt[idx] < 65535) model_cnt[idx]++;
            end
            if (iv && ir) q[idx].push_back(model(in_w, out_w, id, isg));
        end
        hold_prev[idx] = ov && !orr;
        prev_data[idx] = od;
        prev_sat[idx]  = osat;
        rst_prev[idx]  = rst;
    endtask

    // Sample on the falling edge, well away from the rising edge where the DUT updates.
    always @(negedge clk) begin
        observe(0, 3, 5, a_in_valid, a_in_ready, 32'(a_in_data), a_in_signed,
                a_out_valid, a_out_ready, 32'(a_out_data), a_out_sat, 32'(a_sat_count));
        observe(1, 5, 3, b_in_valid, b_in_ready, 32'(b_in_data), b_in_signed,
                b_out_valid, b_out_ready, 32'(b_out_data), b_out_sat, 32'(b_sat_count));
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [2:0] exp_pos;
        logic       exp_pos_sat;
        for (int i = 0; i < 2; i++) begin
            model_cnt[i] = 0;
            hold_prev[i] = 1'b0;
            rst_prev[i]  = 1'b0;
            prev_data[i] = '0;
            prev_sat[i]  = 1'b0;
        end
        rst = 1'b1;
        a_in_valid = 0; a_in_signed = 0; a_in_data = '0; a_out_ready = 0;
        b_in_valid = 0; b_in_signed = 0; b_in_data = '0; b_out_ready = 0;
        cyc();
        cyc();
        check("reset_a_valid", 32'(a_out_valid), 32'd0);
        check("reset_a_ready", 32'(a_in_ready), 32'd1);
        check("reset_b_count", 32'(b_sat_count), 32'd0);
        rst = 1'b0;

        // Random traffic on both instances.
        for (int n = 0; n < 800; n++) begin
            a_in_valid  = 1'($urandom_range(0, 1));
            a_in_signed = 1'($urandom_range(0, 1));
            a_in_data   = 3'($urandom);
            a_out_ready = ($urandom_range(0, 9) < 7);
            b_in_valid  = 1'($urandom_range(0, 1));
            b_in_signed = 1'($urandom_range(0, 1));
            b_in_data   = 5'($urandom);
            b_out_ready = ($urandom_range(0, 9) < 7);
            cyc();
        end

        // Drain, then directed widening cases.
        a_in_valid = 0; b_in_valid = 0; a_out_ready = 1; b_out_ready = 1;
        cyc();
        a_in_valid = 1; a_in_signed = 1; a_in_data = 3'b100;
        cyc();
        check("wide_signed_data", 32'(a_out_data), 32'(5'b11100));
        check("wide_signed_sat", 32'(a_out_sat), 32'd0);
        a_in_signed = 0;
        cyc();
        check("wide_unsigned_data", 32'(a_out_data), 32'(5'b00100));
        a_in_valid = 0;
        cyc();

        // Narrowing: +10 does not fit in 3 signed bits; -2 does.
`ifdef WIDTH_CONVERT_SAT_EN
        exp_pos = 3'b011; exp_pos_sat = 1'b1;
`else
        exp_pos = 3'b010; exp_pos_sat = 1'b0;
`endif
        rst = 1; cyc(); rst = 0;
        b_in_valid = 1; b_in_signed = 1; b_in_data = 5'b01010;
        cyc();
        check("narrow_pos_data", 32'(b_out_data), 32'(exp_pos));
        check("narrow_pos_sat", 32'(b_out_sat), 32'(exp_pos_sat));
        b_in_valid = 0;
        cyc();
        check("narrow_pos_count", 32'(b_sat_count), 32'(exp_pos_sat));
        b_in_valid = 1; b_in_data = 5'b11110;
        cyc();
        check("narrow_neg_data", 32'(b_out_data), 32'(3'b110));
        check("narrow_neg_sat", 32'(b_out_sat), 32'd0);
        b_in_valid = 0;
        cyc();

        // Backpressure on the widening instance.
        a_out_ready = 0; a_in_valid = 1; a_in_signed = 0; a_in_data = 3'b011;
        cyc();
        a_in_data = 3'b101;
        for (int k = 0; k < 3; k++) begin
            cyc();
            check("bp_in_ready", 32'(a_in_ready), 32'd0);
            check("bp_hold_data", 32'(a_out_data), 32'(5'b00011));
        end
        a_out_ready = 1;
        cyc();
        check("bp_release_data", 32'(a_out_data), 32'(5'b00101));
        check("bp_release_valid", 32'(a_out_valid), 32'd1);

        // Reset while a stalled sample is held.
        a_out_ready = 0; a_in_data = 3'b110;
        cyc();
        rst = 1;
        cyc();
        check("rst_drop_valid", 32'(a_out_valid), 32'd0);
        check("rst_drop_ready", 32'(a_in_ready), 32'd1);
        check("rst_drop_count", 32'(a_sat_count), 32'd0);
        rst = 0; a_in_valid = 0; a_out_ready = 1;
        cyc();
        cyc();
        check("rst_no_replay", 32'(a_out_valid), 32'd0);

`ifdef WIDTH_CONVERT_SAT_EN
        // Counter saturation at 16'hFFFF.
        b_in_valid = 1; b_in_signed = 1; b_in_data = 5'b01010; b_out_ready = 1;
        for (int k = 0; k < 65540; k++) cyc();
        check("count_saturate", 32'(b_sat_count), 32'h0000FFFF);
        for (int k = 0; k < 5; k++) cyc();
        check("count_stick", 32'(b_sat_count), 32'h0000FFFF);
        b_in_valid = 0;
        cyc();
`endif

        cyc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
